// File: rtl/ahb_slave_fabric.sv
// rtl/ahb_slave_fabric.sv - AHB-Lite slave decoder, data-phase mux, default error slave and error counter
module ahb_slave_fabric #(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    NUM_SLAVES    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                    REGION_BITS   = 12,
   parameter int                    ERR_CNT_WIDTH = 8
) (
   input  logic                             HCLK,
   input  logic                             HRESETn,
   input  logic [ADDR_WIDTH-1:0]            HADDR,
   input  logic [1:0]                       HTRANS,
   output logic [NUM_SLAVES-1:0]            HSEL_S,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]            HRESP_S,
   output logic [DATA_WIDTH-1:0]            HRDATA,
   output logic                             HREADY,
   output logic                             HRESP,
   input  logic                             err_clr,
   output logic [ERR_CNT_WIDTH-1:0]         err_count
);

   localparam int IDX_W = $clog2(NUM_SLAVES);

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] region;
   logic                  mapped;
   logic [IDX_W-1:0]      dec_idx;
   logic                  err_start;

   logic                  dsel_vld;
   logic [IDX_W-1:0]      dsel_idx;

   logic                  slv_ready;
   logic                  slv_resp;
   logic [DATA_WIDTH-1:0] slv_rdata;

   ds_state_t             ds_state;
   ds_state_t             ds_next;
   logic                  ds_ready;
   logic                  ds_resp;

   // HTRANS[0] only separates NONSEQ from SEQ, which the fabric treats alike
   logic                  unused_htrans;
   assign unused_htrans = HTRANS[0];

   // Address-phase decode: window index and one-hot select, independent of HTRANS
   always_comb begin
      offset  = HADDR - BASE_ADDR;
      region  = offset >> REGION_BITS;
      mapped  = (HADDR >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLAVES));
      dec_idx = region[IDX_W-1:0];
      HSEL_S  = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (mapped && (dec_idx == IDX_W'(k))) begin
            HSEL_S[k] = 1'b1;
         end
      end
   end

   // Data-phase select only advances when the transfer in flight completes
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_vld <= 1'b0;
         dsel_idx <= '0;
      end else if (HREADY) begin
         dsel_vld <= mapped;
         dsel_idx <= dec_idx;
      end
   end

   // Selected slave's response, kept apart from the default slave so the FSM never loops through HREADY
   always_comb begin
      slv_ready = 1'b1;
      slv_resp  = 1'b0;
      slv_rdata = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (dsel_idx == IDX_W'(k)) begin
            slv_ready = HREADYOUT_S[k];
            slv_resp  = HRESP_S[k];
            slv_rdata = HRDATA_S[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // An unmapped NONSEQ/SEQ is accepted whenever the current data phase is not being stalled
   assign err_start = HTRANS[1] && !mapped && (!dsel_vld || slv_ready);

   // Default slave state register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ds_state <= DS_IDLE;
      end else begin
         ds_state <= ds_next;
      end
   end

   // Default slave: two-cycle ERROR; ERR1 always proceeds to ERR2 even if the master cancels
   always_comb begin
      ds_next  = ds_state;
      ds_ready = 1'b1;
      ds_resp  = 1'b0;
      case (ds_state)
         DS_IDLE: begin
            if (err_start) begin
               ds_next = DS_ERR1;
            end
         end
         DS_ERR1: begin
            ds_ready = 1'b0;
            ds_resp  = 1'b1;
            ds_next  = DS_ERR2;
         end
         DS_ERR2: begin
            ds_resp = 1'b1;
            ds_next = err_start ? DS_ERR1 : DS_IDLE;
         end
         default: begin
            ds_next = DS_IDLE;
         end
      endcase
   end

   // Response mux toward the master; the default slave owns the bus when no slave is selected
   always_comb begin
      if (dsel_vld) begin
         HREADY = slv_ready;
         HRESP  = slv_resp;
         HRDATA = slv_rdata;
      end else begin
         HREADY = ds_ready;
         HRESP  = ds_resp;
         HRDATA = '0;
      end
   end

   // Saturating count of completed ERROR responses; clear wins over increment
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (HREADY && HRESP && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ahb_slave_fabric.sv
// tb/tb_ahb_slave_fabric.sv - self-checking bench for ahb_slave_fabric
module tb_ahb_slave_fabric;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int NS      = 4;
   localparam int RB      = 12;
   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam int K_OKAY  = 0;
   localparam int K_SLAVE = 1;
   localparam int K_ERR1  = 2;
   localparam int K_ERR2  = 3;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b1;
   logic [AW-1:0] haddr = '0;
   logic [1:0]    htrans = 2'b00;
   logic [NS-1:0] hsel_s;
   logic [NS*DW-1:0] hrdata_s;
   logic [NS-1:0] hreadyout_s = '1;
   logic [NS-1:0] hresp_s = '0;
   logic [DW-1:0] hrdata;
   logic          hready;
   logic          hresp;
   logic          err_clr = 1'b0;
   logic [CW-1:0] err_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   int m_kind = K_OKAY;
   int m_slave = 0;
   int m_cnt = 0;
   int m_t;
   bit m_rdy;
   bit m_rsp;

   ahb_slave_fabric #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS),
      .BASE_ADDR('0), .REGION_BITS(RB), .ERR_CNT_WIDTH(CW)
   ) dut (
      .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans),
      .HSEL_S(hsel_s), .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s),
      .HRESP_S(hresp_s), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
      .err_clr(err_clr), .err_count(err_count)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // window number of an address, -1 if outside all slave windows (base is 0)
   function automatic int target(input logic [AW-1:0] a);
      longint w;
      w = longint'(a) / (longint'(1) << RB);
      if (w >= NS) return -1;
      return int'(w);
   endfunction

   function automatic logic [NS-1:0] exp_hsel();
      int t;
      t = target(haddr);
      if (t < 0) return '0;
      return NS'(1) << t;
   endfunction

   function automatic bit exp_ready();
      if (m_kind == K_SLAVE) return hreadyout_s[m_slave];
      if (m_kind == K_ERR1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_resp();
      if (m_kind == K_SLAVE) return hresp_s[m_slave];
      if (m_kind == K_ERR1 || m_kind == K_ERR2) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_rdata();
      if (m_kind == K_SLAVE) return hrdata_s[m_slave*DW +: DW];
      return '0;
   endfunction

   // transaction-level model: which kind of data phase is in flight, and the error tally
   initial forever begin
      @(posedge hclk or negedge hresetn);
      if (!hresetn) begin
         m_kind = K_OKAY;
         m_cnt  = 0;
      end else begin
         m_rdy = exp_ready();
         m_rsp = exp_resp();
         m_t   = target(haddr);
         if (err_clr) m_cnt = 0;
         else if (m_rdy && m_rsp && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (m_kind == K_ERR1) begin
            m_kind = K_ERR2;
         end else if (m_rdy) begin
            if (m_t >= 0) begin
               m_kind  = K_SLAVE;
               m_slave = m_t;
            end else if (htrans[1]) begin
               m_kind = K_ERR1;
            end else begin
               m_kind = K_OKAY;
            end
         end
      end
   end

   // every-cycle comparison against the model, mid-cycle
   initial forever begin
      @(negedge hclk);
      if (chk_en) begin
         check("hsel", hsel_s, exp_hsel());
         check("hready", hready, exp_ready());
         check("hresp", hresp, exp_resp());
         check("hrdata", hrdata, exp_rdata());
         check("err_count", err_count, m_cnt);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hrdata_s = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
      #1 hresetn = 1'b0;
      chk_en = 1'b1;
      step();
      step();
      #2;
      check("lit_rst_ready", hready, 1);
      check("lit_rst_resp", hresp, 0);
      check("lit_rst_rdata", hrdata, 0);
      check("lit_rst_cnt", err_count, 0);
      step();
      hresetn = 1'b1;

      // mapped read from slave 1
      step();
      haddr = 32'h1004; htrans = 2'b10;
      #2 check("lit_hsel_1004", hsel_s, 4'b0010);
      step();
      haddr = 32'h0000; htrans = 2'b00;
      #2;
      check("lit_rdata_s1", hrdata, 32'hDEAD_BEEF);
      check("lit_resp_s1", hresp, 0);
      check("lit_cnt_s1", err_count, 0);

      // slave 2 stalls three cycles while the next address waits
      step();
      haddr = 32'h2000; htrans = 2'b10;
      step();
      haddr = 32'h0008; htrans = 2'b10; hreadyout_s[2] = 1'b0;
      #2;
      check("lit_wait_ready", hready, 0);
      check("lit_wait_rdata", hrdata, 32'h2222_2222);
      for (int i = 0; i < 2; i++) begin
         step();
         #2 check("lit_wait_hold", hready, 0);
      end
      step();
      hreadyout_s[2] = 1'b1;
      #2 check("lit_wait_done", hrdata, 32'h2222_2222);
      step();
      haddr = 32'h0000; htrans = 2'b00;
      #2 check("lit_dsel0_rdata", hrdata, 32'h1111_0000);

      // single unmapped NONSEQ, then IDLE to the same hole
      step();
      haddr = 32'h4000; htrans = 2'b10;
      #2 check("lit_hsel_unmapped", hsel_s, 4'b0000);
      step();
      haddr = 32'h0000; htrans = 2'b00;
      #2;
      check("lit_err1_ready", hready, 0);
      check("lit_err1_resp", hresp, 1);
      step();
      haddr = 32'h4000; htrans = 2'b00;
      #2;
      check("lit_err2_ready", hready, 1);
      check("lit_err2_resp", hresp, 1);
      check("lit_err2_rdata", hrdata, 0);
      step();
      #2;
      check("lit_idle_hole_resp", hresp, 0);
      check("lit_cnt_one", err_count, 1);
      step();
      #2 check("lit_cnt_still_one", err_count, 1);

      // back-to-back errors, then slave 0
      step();
      haddr = 32'h4000; htrans = 2'b10;
      step();
      haddr = 32'h5000; htrans = 2'b10;
      #2 check("lit_b2b_err1a", {hready, hresp}, 2'b01);
      step();
      #2 check("lit_b2b_err2a", {hready, hresp}, 2'b11);
      step();
      haddr = 32'h0000; htrans = 2'b10;
      #2 check("lit_b2b_err1b", {hready, hresp}, 2'b01);
      step();
      #2 check("lit_b2b_err2b", {hready, hresp}, 2'b11);
      step();
      htrans = 2'b00;
      #2;
      check("lit_b2b_okay", {hready, hresp}, 2'b10);
      check("lit_cnt_three", err_count, 3);

      // error response coming from a mapped slave
      step();
      err_clr = 1'b1;
      haddr = 32'h3000; htrans = 2'b10;
      step();
      err_clr = 1'b0;
      hreadyout_s[3] = 1'b0; hresp_s[3] = 1'b1;
      haddr = 32'h0000; htrans = 2'b00;
      #2;
      check("lit_clr", err_count, 0);
      check("lit_s3_err1", {hready, hresp}, 2'b01);
      step();
      hreadyout_s[3] = 1'b1;
      #2 check("lit_s3_err2", {hready, hresp}, 2'b11);
      step();
      hresp_s[3] = 1'b0;
      #2 check("lit_s3_cnt", err_count, 1);

      // saturation, then clear on the edge a sixth error completes
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      haddr = 32'h4000; htrans = 2'b10;
      #2 check("lit_sat_start", err_count, 0);
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i == 11) begin
            #2 check("lit_sat_three", err_count, 3);
         end
         if (i == 12) begin
            err_clr = 1'b1; htrans = 2'b00;
            #2 check("lit_sixth_err2", {hready, hresp}, 2'b11);
         end
      end
      step();
      err_clr = 1'b0;
      #2;
      check("lit_clr_wins", err_count, 0);
      check("lit_after_clr_resp", hresp, 0);

      // reset in the middle of an error
      step();
      haddr = 32'h4000; htrans = 2'b10;
      step();
      step();
      step();
      #1 check("lit_pre_rst_cnt", err_count, 1);
      check("lit_pre_rst_err1", {hready, hresp}, 2'b01);
      hresetn = 1'b0;
      #1;
      check("lit_rst_mid_ready", hready, 1);
      check("lit_rst_mid_resp", hresp, 0);
      check("lit_rst_mid_cnt", err_count, 0);
      step();
      hresetn = 1'b1; htrans = 2'b00;
      #2;
      check("lit_post_rst", {hready, hresp}, 2'b10);
      check("lit_post_rst_cnt", err_count, 0);
      step();
      htrans = 2'b10;
      step();
      htrans = 2'b00;
      #2 check("lit_post_rst_err1", {hready, hresp}, 2'b01);
      step();
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_slave_fabric.md
Name: ahb_slave_fabric

Overview:
- Parametrised AHB-Lite single-master interconnect for NUM_SLAVES slaves. It is the next generation of the fixed two-slave decoder/mux pair.
- Contains four parts:
  - combinational address-phase decode;
  - registered data-phase select;
  - response/read-data mux;
  - built-in default slave that returns a two-cycle ERROR for unmapped transfers.
- Keeps a saturating bus-error counter for firmware and debug visibility.
- Sits between the top-level AHB port and the generic_slave instances.

Parameters:
DATA_WIDTH, 32, HWDATA/HRDATA width
ADDR_WIDTH, 32, HADDR width
NUM_SLAVES, 4, number of slave ports, legal range 2..16
BASE_ADDR, 32'h0000_0000, byte address of slave 0 window
REGION_BITS, 12, log2 of window size; slave k occupies BASE_ADDR + k*2^REGION_BITS, with size 2^REGION_BITS
ERR_CNT_WIDTH, 8, width of err_count

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset; one clock; reset is asynchronous and active-low
HADDR  in  ADDR_WIDTH  master address (address phase)
HTRANS  in  2  master transfer type
HSEL_S  out  NUM_SLAVES  one-hot slave select (address phase)
HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  flattened slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
HREADYOUT_S  in  NUM_SLAVES  per-slave ready
HRESP_S  in  NUM_SLAVES  per-slave response, 1 = ERROR
HRDATA  out  DATA_WIDTH  muxed read data to master
HREADY  out  1  muxed ready to master; also fanned back to slaves externally
HRESP  out  1  muxed response to master
err_clr  in  1  synchronous clear of err_count
err_count  out  ERR_CNT_WIDTH  saturating count of completed ERROR responses

Behaviour:
- Decode (combinational):
  - idx = (HADDR - BASE_ADDR) >> REGION_BITS.
  - The address is mapped iff HADDR >= BASE_ADDR and idx < NUM_SLAVES.
  - HSEL_S[idx] = 1 when mapped, independent of HTRANS. All zero when unmapped.
- Data-phase select register dsel:
  - Encodes a slave index or NONE.
  - Loaded from the decode only on a rising HCLK with HREADY=1. Holds while HREADY=0.
  - Reset value: NONE.
- Output mux:
  - dsel=k: HREADY=HREADYOUT_S[k], HRESP=HRESP_S[k], HRDATA=HRDATA_S slice k.
  - dsel=NONE: HREADY and HRESP come from the default slave, and HRDATA=0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: HREADY=1, HRESP=0.
    - Goes to DS_ERR1 when HREADY=1, HTRANS[1]=1 (NONSEQ/SEQ) and the address is unmapped.
    - IDLE or BUSY to an unmapped address stays in DS_IDLE and gives a zero-wait OKAY.
  - DS_ERR1: HREADY=0, HRESP=1. Unconditionally goes to DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1.
    - Samples the next address phase.
    - Unmapped NONSEQ/SEQ goes to DS_ERR1; anything else goes to DS_IDLE.
  - The master may drive IDLE during DS_ERR1 (cancel); the FSM still completes DS_ERR2.
- Reset (async assert, sync deassert handled upstream):
  - dsel=NONE, FSM=DS_IDLE, err_count=0.
  - Outputs during and after reset: HREADY=1, HRESP=0, HRDATA=0.
  - HSEL_S follows HADDR combinationally.
- Reset mid-error: FSM returns to DS_IDLE immediately. No ERROR cycle is completed and err_count is not incremented.
- err_count:
  - +1 on each rising edge where HREADY=1 and HRESP=1, from any source, including the default slave's DS_ERR2.
  - Saturates at 2^ERR_CNT_WIDTH-1.
  - err_clr=1 clears to 0 and takes priority over a simultaneous increment.
- Latency: zero added cycles for mapped slaves. Read data and response are passed combinationally in the data phase.

Test Plan:
- Params NUM_SLAVES=4, REGION_BITS=12, BASE_ADDR=0, ERR_CNT_WIDTH=2. Reset, then NONSEQ read 0x1004 → HSEL_S=4'b0010; slave 1 returns 0xDEADBEEF → HRDATA=0xDEADBEEF, HRESP=0, err_count=0.
- Slave 2 (addr 0x2000) holds HREADYOUT_S[2]=0 for 3 cycles while the next address 0x0008 is presented → dsel stays 2 for 3 cycles, HREADY=0; dsel becomes 0 only after HREADY=1.
- NONSEQ to 0x4000 (unmapped) → next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, HRDATA=0, err_count=1; IDLE to 0x4000 → zero-wait OKAY, count unchanged.
- Back-to-back NONSEQ 0x4000, 0x5000, then 0x0000 → two full ERR1/ERR2 pairs with no DS_IDLE cycle between them; third transfer to slave 0 is OKAY.
- Five error responses → err_count saturates at 3; err_clr asserted on the same edge as a sixth error completes → err_count=0.
- HRESETn asserted during DS_ERR1 → outputs immediately HREADY=1, HRESP=0; after release, err_count=0 and the FSM is in DS_IDLE.
